// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer: buffers sideband packets and shifts them out LSB-first,
// one 97-cycle SB clock controller frame per packet, checking o_ser_done alignment.
//
// Ports:
//   i_pll_clk    PLL clock, shared with the SB clock controller
//   i_rst_n      asynchronous active-low reset
//   i_pkt_valid  packet builder presents i_pkt_data
//   i_pkt_data   packet, bit 0 sent first
//   o_pkt_ready  FIFO not full
//   o_clk_req    one-cycle frame-start pulse to the controller
//   i_ser_done   controller end-of-bits pulse
//   o_txdatasb   serial data toward the TXDATASB pad
//   o_busy       frame in flight or packets queued
//   o_sync_err   sticky i_ser_done misalignment flag
`timescale 1ns/1ps
module sb_tx_serializer #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 33
) (
    input  logic              i_pll_clk,
    input  logic              i_rst_n,
    input  logic              i_pkt_valid,
    input  logic [DATA_W-1:0] i_pkt_data,
    output logic              o_pkt_ready,
    output logic              o_clk_req,
    input  logic              i_ser_done,
    output logic              o_txdatasb,
    output logic              o_busy,
    output logic              o_sync_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_W);
    localparam int GW = $clog2(GAP_CYCLES);

    localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W-1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES-1);
    // Controller registers its counter==DATA_W, so done lands one GAP cycle in
    localparam logic [GW-1:0] GAP_DONE = GW'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [PW:0]       r_count;
    logic [DATA_W-1:0] r_shreg;
    logic [BW-1:0]     r_bit_cnt;
    logic [GW-1:0]     r_gap_cnt;
    logic              r_sync_err;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_gap_last;
    logic w_viol;

    assign w_full     = (r_count == CNT_FULL);
    assign w_empty    = (r_count == '0);
    assign w_push     = i_pkt_valid && !w_full;
    assign w_gap_last = (r_state == GAP) && (r_gap_cnt == GAP_LAST);
    assign w_pop      = !w_empty &&
                        ((r_state == IDLE) || w_gap_last);

    // Done must appear exactly once per frame, at GAP_DONE
    always_comb begin
        w_viol = 1'b0;
        if (r_state == GAP && r_gap_cnt == GAP_DONE) begin
            w_viol = !i_ser_done;
        end else if (r_state != IDLE) begin
            w_viol = i_ser_done;
        end
    end

    // FIFO
    always_ff @(posedge i_pll_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_pkt_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge i_pll_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) w_next = SHIFT;
            end
            SHIFT: begin
                if (r_bit_cnt == BIT_LAST) w_next = GAP;
            end
            GAP: begin
                if (w_gap_last) w_next = w_empty ? IDLE : SHIFT;
            end
            default: w_next = IDLE;
        endcase
    end

    // Shift register, counters, sticky error
    always_ff @(posedge i_pll_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_sync_err <= 1'b0;
        end else begin
            if (w_pop) begin
                r_shreg <= r_mem[r_rptr];
            end else if (r_state == SHIFT) begin
                r_shreg <= r_shreg >> 1;
            end
            if (r_state == SHIFT && r_bit_cnt != BIT_LAST) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end else begin
                r_bit_cnt <= '0;
            end
            if (r_state == GAP && !w_gap_last) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
            if (w_viol) begin
                r_sync_err <= 1'b1;
            end
        end
    end

    // FSM outputs; error is visible in the offending cycle itself
    always_comb begin
        o_pkt_ready = !w_full;
        o_clk_req   = 1'b0;
        o_txdatasb  = 1'b0;
        o_busy      = (r_state != IDLE) || !w_empty;
        o_sync_err  = r_sync_err || w_viol;
        if (r_state == SHIFT) begin
            o_clk_req  = (r_bit_cnt == '0);
            o_txdatasb = r_shreg[0];
        end
    end

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Self-checking bench for sb_tx_serializer: scoreboard of pushed packets,
// per-frame bit monitor, controller done model, and directed corner cases.
`timescale 1ns/1ps
module tb_sb_tx_serializer;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pkt_valid = 1'b0;
    logic [DW-1:0] pkt_data = '0;
    logic          ser_done = 1'b0;
    logic          pkt_ready;
    logic          clk_req;
    logic          txd;
    logic          busy;
    logic          sync_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sd_mode = 0;
    int sd_inj = 10;
    int ctl_cnt = 200;

    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] frames[$];
    int            req_times[$];
    logic [DW-1:0] mon_exp = '0;
    logic [DW-1:0] mon_cap = '0;
    int            mon_idx = 0;
    bit            mon_act = 1'b0;

    typedef struct {
        logic [DW-1:0] pkt;
        logic [11:0]   lsb;
        logic [3:0]    msb;
        int            lat;
    } vec_t;
    vec_t vt[5];

    always #5 clk = ~clk;

    sb_tx_serializer #(
        .DATA_W(64),
        .FIFO_DEPTH(4),
        .GAP_CYCLES(33)
    ) dut (
        .i_pll_clk(clk),
        .i_rst_n(rst_n),
        .i_pkt_valid(pkt_valid),
        .i_pkt_data(pkt_data),
        .o_pkt_ready(pkt_ready),
        .o_clk_req(clk_req),
        .i_ser_done(ser_done),
        .o_txdatasb(txd),
        .o_busy(busy),
        .o_sync_err(sync_err)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: done registered at counter==64, i.e. frame cycle 65
    always @(posedge clk) begin
        #1;
        if (!rst_n) ctl_cnt = 200;
        else if (clk_req) ctl_cnt = 0;
        else if (ctl_cnt < 200) ctl_cnt++;
        ser_done = (sd_mode == 0 && ctl_cnt == 65) ||
                   (sd_mode == 2 && ctl_cnt == sd_inj);
    end

    // Frame monitor and scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            mon_act = 1'b0;
            mon_idx = 0;
        end else begin
            if (clk_req) begin
                chk("req_overlap", 64'(mon_act), 64'd0);
                if (sb_q.size() == 0) begin
                    fail_now("sb_underflow");
                    mon_exp = '0;
                end else begin
                    mon_exp = sb_q.pop_front();
                end
                mon_act = 1'b1;
                mon_idx = 0;
                mon_cap = '0;
                req_times.push_back(cyc);
            end
            if (mon_act) begin
                chk("txd_bit", 64'(txd),
                    64'((mon_idx < 64) ? mon_exp[mon_idx] : 1'b0));
                if (mon_idx < 64) mon_cap[mon_idx] = txd;
                if (mon_idx == 63) frames.push_back(mon_cap);
                mon_idx++;
                if (mon_idx == 97) mon_act = 1'b0;
            end else begin
                chk("txd_idle", 64'(txd), 64'd0);
            end
            if (pkt_valid && pkt_ready) sb_q.push_back(pkt_data);
        end
    end

    task automatic push(input logic [DW-1:0] d, output int acc);
        acc = -1;
        pkt_valid = 1'b1;
        pkt_data = d;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (pkt_ready) begin
                acc = cyc;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        pkt_valid = 1'b0;
        if (acc < 0) fail_now("push_timeout");
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int base, output int r);
        int n;
        n = 0;
        while (req_times.size() <= base && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (req_times.size() > base) begin
            r = req_times[base];
        end else begin
            r = 0;
            fail_now("req_timeout");
        end
    endtask

    task automatic go_neg(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic go_start(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        pkt_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int accs[5];
        int rb;
        int fb;
        int r0;
        int r1;
        int r2;
        logic [DW-1:0] w;

        vt[0] = '{64'hA5A5_0000_FFFF_1234, 12'h234, 4'hA, 2};
        vt[1] = '{64'h8000_0000_0000_0001, 12'h001, 4'h8, 2};
        vt[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 12'hFFF, 4'hF, 2};
        vt[3] = '{64'h0123_4567_89AB_CDEF, 12'hDEF, 4'h0, 2};
        vt[4] = '{64'h0000_0000_0000_0000, 12'h000, 4'h0, 2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(pkt_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_txd", 64'(txd), 64'd0);
        chk("rst_req", 64'(clk_req), 64'd0);
        chk("rst_err", 64'(sync_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single packets from the vector table
        for (int i = 0; i < 5; i++) begin
            fb = frames.size();
            rb = req_times.size();
            push(vt[i].pkt, acc);
            @(negedge clk);
            chk("idle_busy", 64'(busy), 64'd1);
            chk("idle_no_req", 64'(clk_req), 64'd0);
            wait_idle();
            if (frames.size() == fb + 1) begin
                w = frames[fb];
                chk("vec_lsb12", 64'(w[11:0]), 64'(vt[i].lsb));
                chk("vec_msb4", 64'(w[63:60]), 64'(vt[i].msb));
            end else begin
                fail_now("vec_frame_missing");
            end
            if (req_times.size() > rb)
                chk("vec_latency", 64'(req_times[rb] - acc), 64'(vt[i].lat));
            else
                fail_now("vec_no_req");
        end

        // Three back-to-back packets with the controller model attached
        rb = req_times.size();
        fb = frames.size();
        push(64'h1111_2222_3333_4444, acc);
        push(64'hDEAD_BEEF_CAFE_F00D, acc);
        push(64'h0F0F_F0F0_5555_AAAA, acc);
        wait_idle();
        chk("b2b_frames", 64'(frames.size() - fb), 64'd3);
        if (req_times.size() >= rb + 3) begin
            chk("b2b_period1", 64'(req_times[rb+1] - req_times[rb]), 64'd97);
            chk("b2b_period2", 64'(req_times[rb+2] - req_times[rb+1]), 64'd97);
        end else begin
            fail_now("b2b_req_count");
        end
        chk("b2b_sync_err", 64'(sync_err), 64'd0);

        // FIFO fill: pop at first IDLE cycle lets a fifth push in
        fb = frames.size();
        for (int i = 0; i < 5; i++) begin
            push(64'(i + 1) * 64'h0101_0101_0101_0101 + 64'h8000_0000_0000_0000, accs[i]);
        end
        for (int i = 1; i < 5; i++) begin
            chk("fill_consecutive", 64'(accs[i] - accs[i-1]), 64'd1);
        end
        @(negedge clk);
        chk("fill_ready_low", 64'(pkt_ready), 64'd0);
        @(posedge clk);
        #1;
        push(64'h6666_6666_6666_6666, acc);
        wait_idle();
        chk("fill_frames", 64'(frames.size() - fb), 64'd6);
        chk("fill_sb_empty", 64'(sb_q.size()), 64'd0);
        chk("fill_sync_err", 64'(sync_err), 64'd0);

        // Late push timing around the last GAP cycle
        rb = req_times.size();
        push(64'h0000_0000_0000_00A1, acc);
        wait_req(rb, r0);
        go_start(r0 + 95);
        push(64'h0000_0000_0000_00B2, acc);
        chk("late_acc_cycle", 64'(acc - r0), 64'd95);
        wait_req(rb + 1, r1);
        chk("late_no_gap", 64'(r1 - r0), 64'd97);
        go_start(r1 + 96);
        push(64'h0000_0000_0000_00C3, acc);
        wait_req(rb + 2, r2);
        chk("late_idle_gap", 64'(r2 - r1), 64'd98);
        wait_idle();

        // Done never arrives: error in GAP cycle 1, sticky afterwards
        sd_mode = 1;
        rb = req_times.size();
        push(64'h1234_5678_9ABC_DEF0, acc);
        push(64'h0FED_CBA9_8765_4321, acc);
        wait_req(rb, r0);
        go_neg(r0 + 64);
        chk("nodone_err_c64", 64'(sync_err), 64'd0);
        @(negedge clk);
        chk("nodone_err_c65", 64'(sync_err), 64'd1);
        wait_req(rb + 1, r1);
        go_neg(r1 + 30);
        chk("nodone_err_f2", 64'(sync_err), 64'd1);
        wait_idle();
        @(negedge clk);
        chk("nodone_err_idle", 64'(sync_err), 64'd1);
        do_reset();
        chk("nodone_err_rst", 64'(sync_err), 64'd0);

        // Early done in SHIFT cycle 10
        sd_mode = 2;
        sd_inj = 10;
        rb = req_times.size();
        push(64'hAAAA_5555_AAAA_5555, acc);
        wait_req(rb, r0);
        go_neg(r0 + 9);
        chk("early_err_c9", 64'(sync_err), 64'd0);
        @(negedge clk);
        chk("early_err_c10", 64'(sync_err), 64'd1);
        @(negedge clk);
        chk("early_err_c11", 64'(sync_err), 64'd1);
        wait_idle();
        do_reset();
        sd_mode = 0;

        // Reset mid-frame with two packets queued
        rb = req_times.size();
        push(64'hFFFF_FFFF_FFFF_FFFF, acc);
        push(64'hFFFF_FFFF_FFFF_FFFF, acc);
        push(64'hFFFF_FFFF_FFFF_FFFF, acc);
        wait_req(rb, r0);
        go_neg(r0 + 20);
        chk("mid_txd", 64'(txd), 64'd1);
        chk("mid_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_txd", 64'(txd), 64'd0);
        chk("arst_req", 64'(clk_req), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_err", 64'(sync_err), 64'd0);
        chk("arst_ready", 64'(pkt_ready), 64'd1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 64'(pkt_ready), 64'd1);
        chk("rel_busy", 64'(busy), 64'd0);
        rb = req_times.size();
        repeat (10) @(negedge clk);
        chk("rel_no_req", 64'(req_times.size() - rb), 64'd0);
        chk("rel_busy_later", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
